// File: rtl/ram_pair_reducer.sv
`default_nettype none
// ============================================================================
// Module   : ram_pair_reducer
// Purpose  : Sweeps the first `length` entries of a 16x8 dual-read-port RAM,
//            two entries per cycle, and reports their unsigned sum and
//            maximum with a one-cycle done pulse. Read-only RAM consumer.
// Ports    : clock        - rising-edge clock shared with the RAM
//            resetN       - asynchronous active-low reset
//            start        - reduction request, honoured only in IDLE
//            length       - entries to reduce (0..16, larger values clamp)
//            readAddress1 - RAM port 1 address (even entry of the pair)
//            readAddress2 - RAM port 2 address (odd entry of the pair)
//            readData1/2  - combinational RAM read data for the addresses
//            busy         - high whenever the block is not IDLE
//            done         - one-cycle pulse, sum/maxValue valid
//            sum          - unsigned sum of the reduced entries
//            maxValue     - unsigned maximum of the reduced entries
// Revision : 1.0 - initial release
// ============================================================================
module ram_pair_reducer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int SUM_WIDTH  = 12
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] readAddress1,
  output logic [ADDR_WIDTH-1:0] readAddress2,
  input  logic [DATA_WIDTH-1:0] readData1,
  input  logic [DATA_WIDTH-1:0] readData2,
  output logic                  busy,
  output logic                  done,
  output logic [SUM_WIDTH-1:0]  sum,
  output logic [DATA_WIDTH-1:0] maxValue
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } stateType;

  // Full RAM depth (2**ADDR_WIDTH) expressed in the length width.
  localparam logic [ADDR_WIDTH:0]   c_depth       = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   c_two         = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH-1:0] c_pointerStep = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [ADDR_WIDTH-1:0] c_oddOffset   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam int                    c_sumPad      = SUM_WIDTH - DATA_WIDTH;

  stateType              r_state;
  stateType              w_nextState;
  logic [ADDR_WIDTH-1:0] r_pointer;
  logic [ADDR_WIDTH-1:0] w_nextPointer;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH:0]   w_nextRemaining;
  logic [SUM_WIDTH-1:0]  r_sum;
  logic [SUM_WIDTH-1:0]  w_nextSum;
  logic [DATA_WIDTH-1:0] r_maxValue;
  logic [DATA_WIDTH-1:0] w_nextMax;

  // Port 2 data only counts when at least two entries are still pending;
  // on an odd tail it addresses a real (in-range) entry that is ignored.
  logic                  w_useSecond;
  logic [SUM_WIDTH-1:0]  w_ext1;
  logic [SUM_WIDTH-1:0]  w_ext2;
  logic [DATA_WIDTH-1:0] w_firstMax;

  assign w_useSecond = (r_remaining >= c_two);
  assign w_ext1      = {{c_sumPad{1'b0}}, readData1};
  assign w_ext2      = w_useSecond ? {{c_sumPad{1'b0}}, readData2} : '0;
  assign w_firstMax  = (readData1 > r_maxValue) ? readData1 : r_maxValue;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= IDLE;
      r_pointer   <= '0;
      r_remaining <= '0;
      r_sum       <= '0;
      r_maxValue  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_pointer   <= w_nextPointer;
      r_remaining <= w_nextRemaining;
      r_sum       <= w_nextSum;
      r_maxValue  <= w_nextMax;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextPointer   = r_pointer;
    w_nextRemaining = r_remaining;
    w_nextSum       = r_sum;
    w_nextMax       = r_maxValue;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextRemaining = (length > c_depth) ? c_depth : length;
          w_nextPointer   = '0;
          w_nextSum       = '0;
          w_nextMax       = '0;
          w_nextState     = (length != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        w_nextSum = r_sum + w_ext1 + w_ext2;
        w_nextMax = (w_useSecond && (readData2 > w_firstMax)) ? readData2 : w_firstMax;
        if (r_remaining <= c_two) begin
          // Last pair: park the pointer at 0 so DONE/IDLE present addresses 0/1.
          w_nextState     = DONE;
          w_nextPointer   = '0;
          w_nextRemaining = '0;
        end else begin
          w_nextPointer   = r_pointer + c_pointerStep;
          w_nextRemaining = r_remaining - c_two;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign readAddress1 = r_pointer;
  assign readAddress2 = r_pointer + c_oddOffset;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign sum          = r_sum;
  assign maxValue     = r_maxValue;

endmodule
`default_nettype wire

// File: tb/tb_ram_pair_reducer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_pair_reducer
// Purpose  : Self-checking bench for ram_pair_reducer. The bench models the
//            16x8 RAM as an array with combinational reads and predicts sum,
//            maximum and done latency directly from the array contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_pair_reducer;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       start = 1'b0;
  logic [4:0] length = '0;
  logic [3:0] readAddress1;
  logic [3:0] readAddress2;
  logic [7:0] readData1;
  logic [7:0] readData2;
  logic       busy;
  logic       done;
  logic [11:0] sum;
  logic [7:0] maxValue;

  logic [7:0] mem [16];

  int checkCount = 0;
  int failCount  = 0;

  always #5 clock = ~clock;

  assign readData1 = mem[readAddress1];
  assign readData2 = mem[readAddress2];

  ram_pair_reducer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .SUM_WIDTH (12)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .start       (start),
    .length      (length),
    .readAddress1(readAddress1),
    .readAddress2(readAddress2),
    .readData1   (readData1),
    .readData2   (readData2),
    .busy        (busy),
    .done        (done),
    .sum         (sum),
    .maxValue    (maxValue)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic fillCounting();
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
  endtask

  task automatic fillConstant(input logic [7:0] value);
    for (int i = 0; i < 16; i++) mem[i] = value;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // One full reduction: prediction from the array, then cycle-by-cycle checks
  // of addresses and busy, done timing, results and post-done hold.
  task automatic runReduce(input int len, input bit pokeStart);
    int effLen;
    int expSum;
    int expMax;
    int expEdges;
    int edges;
    int k;
    logic [11:0] heldSum;
    logic [7:0]  heldMax;
    effLen = (len > 16) ? 16 : len;
    expSum = 0;
    expMax = 0;
    for (int i = 0; i < effLen; i++) begin
      expSum += int'(mem[i]);
      if (int'(mem[i]) > expMax) expMax = int'(mem[i]);
    end
    expEdges = (effLen + 1) / 2 + 1;

    @(negedge clock);
    start  = 1'b1;
    length = 5'(len);
    @(posedge clock);
    #1;
    start  = 1'b0;
    length = 5'($urandom_range(0, 31));
    edges  = 1;
    k      = 0;
    while (!done && edges < 40) begin
      checkValue("scanAddr1", 32'(readAddress1), 32'(2 * k));
      checkValue("scanAddr2", 32'(readAddress2), 32'(2 * k + 1));
      checkValue("scanBusy", 32'(busy), 32'd1);
      if (pokeStart) start = 1'b1;
      k++;
      @(posedge clock);
      #1;
      start  = 1'b0;
      length = 5'($urandom_range(0, 31));
      edges++;
    end
    checkValue("doneSeen", 32'(done), 32'd1);
    checkValue("doneLatency", 32'(edges), 32'(expEdges));
    checkValue("doneBusy", 32'(busy), 32'd1);
    checkValue("sum", 32'(sum), 32'(expSum));
    checkValue("maxValue", 32'(maxValue), 32'(expMax));
    checkValue("doneAddr1", 32'(readAddress1), 32'd0);
    checkValue("doneAddr2", 32'(readAddress2), 32'd1);
    heldSum = sum;
    heldMax = maxValue;
    @(posedge clock);
    #1;
    checkValue("donePulse", 32'(done), 32'd0);
    checkValue("idleBusy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    checkValue("holdSum", 32'(sum), 32'(expSum));
    checkValue("holdMax", 32'(maxValue), 32'(expMax));
    checkValue("holdStable", 32'({heldSum, heldMax}), 32'({sum, maxValue}));
  endtask

  initial begin
    fillCounting();
    #12;
    checkValue("resetBusy", 32'(busy), 32'd0);
    checkValue("resetDone", 32'(done), 32'd0);
    checkValue("resetSum", 32'(sum), 32'd0);
    checkValue("resetMax", 32'(maxValue), 32'd0);
    checkValue("resetAddr1", 32'(readAddress1), 32'd0);
    checkValue("resetAddr2", 32'(readAddress2), 32'd1);
    @(negedge clock);
    resetN = 1'b1;

    // Directed cases from the datasheet scenarios.
    fillCounting();
    runReduce(16, 1'b0);
    runReduce(5, 1'b0);
    runReduce(0, 1'b0);
    fillConstant(8'hFF);
    runReduce(16, 1'b0);
    fillCounting();
    runReduce(20, 1'b0);
    runReduce(16, 1'b1);
    runReduce(1, 1'b0);
    runReduce(15, 1'b0);

    // Asynchronous reset in the middle of a sweep, away from any clock edge.
    fillCounting();
    @(negedge clock);
    start  = 1'b1;
    length = 5'd16;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checkValue("preResetBusy", 32'(busy), 32'd1);
    resetN = 1'b0;
    #1;
    checkValue("asyncBusy", 32'(busy), 32'd0);
    checkValue("asyncDone", 32'(done), 32'd0);
    checkValue("asyncSum", 32'(sum), 32'd0);
    checkValue("asyncMax", 32'(maxValue), 32'd0);
    checkValue("asyncAddr1", 32'(readAddress1), 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
    checkValue("postResetIdle", 32'(busy), 32'd0);
    runReduce(16, 1'b0);

    // Random contents, lengths (including clamped values) and start pokes.
    for (int r = 0; r < 25; r++) begin
      fillRandom();
      runReduce($urandom_range(0, 31), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire
